sram_frame_writer: RTL and testbench



---
 rtl/sram_frame_writer.sv | 217 +++++++++++++++++++++
 tb/tb_sram_frame_writer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sram_frame_writer.sv
// rtl/sram_frame_writer.sv - raster RGB pixel stream to byte-packed 16-bit SRAM frame writer
//
// Writes one frame per start pulse. Each pixel occupies three consecutive SRAM
// words (R, G, B). Left half-line pixels use the low byte lane and right
// half-line pixels use the high byte lane of the same words.
//
// Optional feature macro: WRITER_GRAY_EN
//   When defined, the latched pixel is replaced by its luma
//   Y = (77*R + 150*G + 29*B) >> 8, and Y is written as all three channels.
//
// Ports:
//   SRAM_CLK   in   1   sole clock, rising edge
//   RST_N      in   1   synchronous reset, active-high
//   i_start    in   1   arms a frame write (IDLE only)
//   i_valid    in   1   pixel on i_rgb is valid
//   i_rgb      in  24   {R, G, B}
//   o_ready    out  1   pixel accepted this cycle when i_valid is high
//   o_busy     out  1   frame write in progress
//   o_done     out  1   one-cycle pulse after the last byte write
//   SRAM_ADDR  out 20   word address
//   SRAM_DQ_O  out 16   write data, channel byte on both lanes
//   SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N  out  active-low controls
module sram_frame_writer #(
    parameter int          WIDTH     = 640,
    parameter int          HEIGHT    = 480,
    parameter logic [19:0] BASE_ADDR = 20'd0
) (
    input  logic        SRAM_CLK,
    input  logic        RST_N,
    input  logic        i_start,
    input  logic        i_valid,
    input  logic [23:0] i_rgb,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic [19:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_O,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N
);

    localparam int          HALF     = WIDTH / 2;
    localparam int          XW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int          YW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [19:0] ROW_STEP = 20'(3 * HALF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WR_R,
        S_WR_G,
        S_WR_B,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [19:0] col_q, col_d;
    logic [19:0] row_q, row_d;
    logic [23:0] pix_q, pix_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] dq_q, dq_d;
    logic        we_n_q, we_n_d;
    logic        ce_n_q, ce_n_d;
    logic        lb_n_q, lb_n_d;
    logic        ub_n_q, ub_n_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [23:0] pix_in;
    logic        left_half;
    logic        last_px;
    logic        line_end;
    logic        wr_next;

`ifdef WRITER_GRAY_EN
    logic [15:0] luma;
    always_comb begin
        luma   = 16'd77  * {8'd0, i_rgb[23:16]}
               + 16'd150 * {8'd0, i_rgb[15:8]}
               + 16'd29  * {8'd0, i_rgb[7:0]};
        pix_in = {luma[15:8], luma[15:8], luma[15:8]};
    end
`else
    assign pix_in = i_rgb;
`endif

    assign left_half = (32'(x_q) < HALF);
    assign line_end  = (x_q == XW'(WIDTH - 1));
    assign last_px   = line_end && (y_q == YW'(HEIGHT - 1));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        row_d   = row_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        dq_d    = dq_q;
        lb_n_d  = lb_n_q;
        ub_n_d  = ub_n_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_ACCEPT;
                    x_d     = '0;
                    y_d     = '0;
                    col_d   = '0;
                    row_d   = BASE_ADDR;
                end
            end
            S_ACCEPT: begin
                if (i_valid) begin
                    state_d = S_WR_R;
                    pix_d   = pix_in;
                    addr_d  = row_q + col_q;
                    dq_d    = {pix_in[23:16], pix_in[23:16]};
                    lb_n_d  = !left_half;
                    ub_n_d  = left_half;
                end
            end
            S_WR_R: begin
                state_d = S_WR_G;
                addr_d  = addr_q + 20'd1;
                dq_d    = {pix_q[15:8], pix_q[15:8]};
            end
            S_WR_G: begin
                state_d = S_WR_B;
                addr_d  = addr_q + 20'd1;
                dq_d    = {pix_q[7:0], pix_q[7:0]};
            end
            S_WR_B: begin
                state_d = last_px ? S_DONE : S_ACCEPT;
                lb_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                if (line_end) begin
                    x_d   = '0;
                    y_d   = last_px ? '0 : y_q + YW'(1);
                    col_d = '0;
                    row_d = row_q + ROW_STEP;
                end else if (x_q == XW'(HALF - 1)) begin
                    // right half reuses the same words as the left half
                    x_d   = x_q + XW'(1);
                    col_d = '0;
                end else begin
                    x_d   = x_q + XW'(1);
                    col_d = col_q + 20'd3;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        wr_next = (state_d == S_WR_R) || (state_d == S_WR_G) || (state_d == S_WR_B);
        we_n_d  = !wr_next;
        ce_n_d  = !wr_next;
        ready_d = (state_d == S_ACCEPT);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge SRAM_CLK) begin
        if (RST_N) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            row_q   <= BASE_ADDR;
            pix_q   <= '0;
            addr_q  <= BASE_ADDR;
            dq_q    <= '0;
            we_n_q  <= 1'b1;
            ce_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            we_n_q  <= we_n_d;
            ce_n_q  <= ce_n_d;
            lb_n_q  <= lb_n_d;
            ub_n_q  <= ub_n_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_DQ_O = dq_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_OE_N = 1'b1;
    assign SRAM_LB_N = lb_n_q;
    assign SRAM_UB_N = ub_n_q;

endmodule

// File: tb/tb_sram_frame_writer.sv
// tb/tb_sram_frame_writer.sv - directed self-checking bench for sram_frame_writer (4x2 frame)
module tb_sram_frame_writer;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int HALF = W / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        i_valid;
    logic [23:0] i_rgb;
    logic        o_ready, o_busy, o_done;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq;
    logic        we_n, ce_n, oe_n, lb_n, ub_n;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_acc;
    int first_acc;
    int c_done;

    logic [23:0] pix [8];

    sram_frame_writer #(.WIDTH(W), .HEIGHT(H), .BASE_ADDR(20'd0)) dut (
        .SRAM_CLK (clk),
        .RST_N    (rst),
        .i_start  (i_start),
        .i_valid  (i_valid),
        .i_rgb    (i_rgb),
        .o_ready  (o_ready),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .SRAM_ADDR(sram_addr),
        .SRAM_DQ_O(sram_dq),
        .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n),
        .SRAM_LB_N(lb_n),
        .SRAM_UB_N(ub_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [23:0] p, input int c);
`ifdef WRITER_GRAY_EN
        logic [15:0] l;
        l = 16'd77 * {8'd0, p[23:16]} + 16'd150 * {8'd0, p[15:8]} + 16'd29 * {8'd0, p[7:0]};
        return l[15:8];
`else
        case (c)
            0:       return p[23:16];
            1:       return p[15:8];
            default: return p[7:0];
        endcase
`endif
    endfunction

    task automatic idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(o_ready), 32'd0);
        chk({tag, "_busy"},  32'(o_busy),  32'd0);
        chk({tag, "_done"},  32'(o_done),  32'd0);
        chk({tag, "_we"},    32'(we_n),    32'd1);
        chk({tag, "_ce"},    32'(ce_n),    32'd1);
        chk({tag, "_lbub"},  32'({lb_n, ub_n, oe_n}), 32'b111);
    endtask

    // Called just after a falling edge; returns at the falling edge of the B write cycle.
    task automatic send(input logic [23:0] p, input int k, input int gap, input bit poke_start);
        int  x;
        int  y;
        logic [7:0] b;
        x = k % W;
        y = k / W;
        for (int n = 0; n < 10 && o_ready !== 1'b1; n++) @(negedge clk);
        chk("ready_wait", 32'(o_ready), 32'd1);
        repeat (gap) @(negedge clk);
        i_valid  = 1'b1;
        i_rgb    = p;
        last_acc = cyc;
        @(negedge clk);
        i_valid = 1'b0;
        i_rgb   = 24'h5A5A5A;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            b = exp_byte(p, c);
            chk($sformatf("addr_p%0d_c%0d", k, c), 32'(sram_addr),
                32'(y * 3 * HALF + 3 * (x % HALF) + c));
            chk($sformatf("dq_p%0d_c%0d", k, c), 32'(sram_dq), 32'({b, b}));
            chk($sformatf("lb_p%0d_c%0d", k, c), 32'(lb_n), (x < HALF) ? 32'd0 : 32'd1);
            chk($sformatf("ub_p%0d_c%0d", k, c), 32'(ub_n), (x < HALF) ? 32'd1 : 32'd0);
            chk($sformatf("we_p%0d_c%0d", k, c), 32'({we_n, ce_n, oe_n}), 32'b001);
            chk($sformatf("ready_p%0d_c%0d", k, c), 32'(o_ready), 32'd0);
            if (c == 1 && poke_start) i_start = 1'b1;
            if (c == 2) i_start = 1'b0;
        end
    endtask

    task automatic frame_end(input string tag);
        @(negedge clk);
        chk({tag, "_done_hi"}, 32'(o_done), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(o_busy), 32'd1);
        chk({tag, "_we_in_done"}, 32'({we_n, ce_n}), 32'b11);
        c_done = cyc;
        @(negedge clk);
        chk({tag, "_done_lo"}, 32'(o_done), 32'd0);
        chk({tag, "_busy_lo"}, 32'(o_busy), 32'd0);
        chk({tag, "_ready_lo"}, 32'(o_ready), 32'd0);
    endtask

    initial begin
        pix = '{24'h112233, 24'hAABBCC, 24'h010203, 24'hFF0000,
                24'h00FF00, 24'h0000FF, 24'h808080, 24'h7E8192};
        rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_rgb = '0;
        repeat (2) @(negedge clk);
        idle_outputs("reset");
        chk("reset_addr", 32'(sram_addr), 32'd0);
        chk("reset_dq", 32'(sram_dq), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        idle_outputs("idle");

        // start with a simultaneous valid: the pixel must not be taken
        i_start = 1'b1; i_valid = 1'b1; i_rgb = 24'hDEADBE;
        @(negedge clk);
        i_start = 1'b0; i_valid = 1'b0;
        chk("arm_ready", 32'(o_ready), 32'd1);
        chk("arm_busy", 32'(o_busy), 32'd1);
        chk("arm_nowrite", 32'(we_n), 32'd1);

        // frame 1: back-to-back pixels, extra start poked mid-write
        for (int k = 0; k < 8; k++) begin
            send(pix[k], k, 0, k == 2);
            if (k == 0) first_acc = last_acc;
        end
        frame_end("f1");
        chk("f1_cycles", 32'(c_done - first_acc + 1), 32'd33);

        // frame 2: random backpressure gaps
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int k = 0; k < 8; k++) send(pix[k] ^ 24'h0F0F0F, k, $urandom_range(0, 3), 1'b0);
        frame_end("f2");

        // reset during the G write
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_valid = 1'b1; i_rgb = 24'h445566;
        @(negedge clk);
        i_valid = 1'b0;
        chk("rstw_r_we", 32'(we_n), 32'd0);
        @(negedge clk);
        chk("rstw_g_addr", 32'(sram_addr), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_outputs("rstw");
        chk("rstw_addr", 32'(sram_addr), 32'd0);
        chk("rstw_dq", 32'(sram_dq), 32'd0);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        send(24'h778899, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=stuck expected=finish");
        $fatal(1, "timeout");
    end

endmodule
